psum_accum: RTL and testbench
=============================

Name: psum_accum

Overview:
- Partial-sum accumulator that sits directly downstream of the 3-tap fixed-point dot-product stage in each PE.
- Takes its 16-bit Q4.12 results over a valid/ready stream and accumulates them into a register-file scratchpad, one entry per output position.
- Accumulation runs over a configurable number of passes (filter rows / channels).
- After the last pass, the final psums drain to the next PE or the GLB over a second valid/ready stream.

Parameters:
- DWIDTH, 16, psum/data width, Q4.12 signed.
- DEPTH, 16, scratchpad entries (max output positions per row).
- LW, $clog2(DEPTH)+1, width of cfg_len.
- PW, 4, width of cfg_passes.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; latches cfg_len and cfg_passes, begins a job.
- cfg_len  in  LW  output positions per pass.
- cfg_passes  in  PW  number of accumulation passes.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse after the last drain handshake.
- in_valid  in  1  upstream product valid.
- in_ready  out  1  high only in ACCUM.
- in_data  in  DWIDTH  signed Q4.12 product from the 3-tap stage.
- out_valid  out  1  final psum valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DWIDTH  final signed Q4.12 psum.

Behaviour:
- States IDLE, ACCUM, DRAIN.
- Reset (rst_n low at an edge, in any state, including mid-job):
  - state=IDLE; busy, done, in_ready, out_valid = 0; out_data = 0; idx = 0; pass = 0.
  - Scratchpad contents are not cleared; pass 0 overwrites them.
- Configuration clamping at start:
  - Effective len L = cfg_len, except cfg_len==0 or cfg_len>DEPTH gives L=DEPTH.
  - Effective passes P = cfg_passes, except cfg_passes==0 gives P=1.
- IDLE:
  - start=1 latches L and P, clears idx and pass, goes to ACCUM next cycle.
  - start is ignored in ACCUM and DRAIN.
- ACCUM:
  - in_ready=1. A handshake occurs when in_valid && in_ready.
  - On a handshake: pass==0 writes spad[idx]=in_data; otherwise writes spad[idx]=spad[idx]+in_data. The write is visible the following cycle.
  - idx increments each handshake. At idx==L-1, idx wraps to 0 and pass increments.
  - The handshake with idx==L-1 and pass==P-1 moves the block to DRAIN. in_ready is low from the next cycle on.
  - No handshake means spad, idx and pass all hold.
- DRAIN:
  - out_valid=1 and out_data=spad[idx], valid from the first DRAIN cycle.
  - On out_valid && out_ready, idx increments.
  - The handshake at idx==L-1 moves the block to IDLE and pulses done=1 for one cycle, coinciding with the first IDLE cycle. out_valid goes low in that cycle.
  - While out_ready=0, out_valid and out_data hold stable.
- Arithmetic:
  - Signed two's-complement DWIDTH add; no rescaling, since inputs are already Q4.12.
  - Overflow handling is selected by the optional feature below.
- Throughput and latency:
  - One input per cycle in ACCUM; one output per cycle in DRAIN.
  - Last input handshake to first out_valid: 1 cycle.
  - Total job length with no stalls: L*P + L + 1 cycles from start to done.
- A job with L=1, P=1 is legal: one input, then one output.

Optional Feature:
- Macro PSUM_SAT_EN.
- Defined: accumulate adds saturate to signed limits, 0x7FFF on positive overflow and 0x8000 on negative overflow.
- Undefined: adds wrap modulo 2^DWIDTH.
- Pass 0 writes are never affected, with or without the macro.

Test Plan:
- Basic accumulation, macro undefined or defined: L=3, P=2.
  - Stimulus: inputs 0x1000, 0x2000, 0x0800, then 0x1000, 0xF000, 0x0800.
  - Required: outputs 0x2000, 0x1000, 0x1000; done pulses 1 cycle after the third output handshake.
- Overflow: L=1, P=2, inputs 0x7000 then 0x2000.
  - Required: output 0x7FFF with PSUM_SAT_EN; 0x9000 without.
  - Also: inputs 0x9000, 0xC000 give 0x8000 with the macro and 0x5000 without.
- Backpressure: L=2, P=1, inputs 0x0100, 0x0200, out_ready held 0 for 5 cycles.
  - Required: out_valid=1 with out_data=0x0100 stable for all 5 cycles.
  - Required: after release, 0x0100 then 0x0200, then done.
- Input bubbles and clamping:
  - L=4, P=3, in_valid toggled every other cycle with all inputs 0x0400. Required: four outputs of 0x0C00; idx/pass hold on bubbles.
  - cfg_len=0 gives DEPTH outputs. cfg_passes=0 behaves as P=1.
- Reset mid-job: rst_n=0 for 1 cycle during ACCUM, pass 1.
  - Required: next cycle IDLE, busy=0, in_ready=0, out_valid=0.
  - Required: a new job L=2, P=1 with inputs 0x0010, 0x0020 outputs exactly 0x0010, 0x0020, with no stale sums.
- start ignored while busy: pulse start during DRAIN.
  - Required: the drain completes unchanged, the block returns to IDLE, and no new job begins.

Source files
------------

// File: rtl/psum_accum.sv
// psum_accum: partial-sum accumulator placed after the 3-tap dot-product stage.
// Q4.12 products arrive on a valid/ready stream and are summed into a
// register-file scratchpad (one entry per output position) over a configurable
// number of passes. The final psums then drain on a second valid/ready stream.
//
// Optional feature: define PSUM_SAT_EN to make accumulate adds saturate to
// 0x7FFF / 0x8000. Without it, adds wrap modulo 2^DWIDTH.
//
// Ports:
//   clk, rst_n              clock (rising edge), synchronous active-low reset
//   start                   one-cycle pulse in IDLE; latches cfg_len/cfg_passes
//   cfg_len [LW]            output positions per pass (0 or >DEPTH -> DEPTH)
//   cfg_passes [PW]         number of accumulation passes (0 -> 1)
//   busy                    high while a job is in progress
//   done                    one-cycle pulse after the last drain handshake
//   in_valid/in_ready/in_data     product stream (in_ready high only in ACCUM)
//   out_valid/out_ready/out_data  final psum stream (valid only in DRAIN)
module psum_accum #(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 16,
  parameter int LW     = $clog2(DEPTH) + 1,
  parameter int PW     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LW-1:0]     cfg_len,
  input  logic [PW-1:0]     cfg_passes,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t            state_reg;
  logic [LW-1:0]     len_reg;
  logic [LW-1:0]     idx_reg;
  logic [PW-1:0]     passes_reg;
  logic [PW-1:0]     pass_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              in_ready_reg;
  logic              out_valid_reg;
  logic [DWIDTH-1:0] out_data_reg;

  logic [DWIDTH-1:0] spad_rd [DEPTH];
  logic [DWIDTH-1:0] cur_val;
  logic [DWIDTH-1:0] add_val;
  logic [DWIDTH-1:0] wr_val;
  logic [LW-1:0]     len_eff;
  logic [PW-1:0]     passes_eff;
  logic [AW-1:0]     rd_next_addr;
  logic              in_hs;
  logic              out_hs;
  logic              idx_last;
  logic              pass_last;

  assign len_eff    = (cfg_len == '0 || cfg_len > LW'(DEPTH)) ? LW'(DEPTH) : cfg_len;
  assign passes_eff = (cfg_passes == '0) ? PW'(1) : cfg_passes;

  // in_ready_reg is high exactly in ACCUM and out_valid_reg exactly in DRAIN,
  // so the handshakes need no extra state qualification.
  assign in_hs     = in_valid && in_ready_reg;
  assign out_hs    = out_valid_reg && out_ready;
  assign idx_last  = (idx_reg == len_reg - LW'(1));
  assign pass_last = (pass_reg == passes_reg - PW'(1));

  assign cur_val      = spad_rd[idx_reg[AW-1:0]];
  assign rd_next_addr = idx_reg[AW-1:0] + AW'(1);

`ifdef PSUM_SAT_EN
  logic [DWIDTH:0] sum_wide;
  always_comb begin
    sum_wide = {cur_val[DWIDTH-1], cur_val} + {in_data[DWIDTH-1], in_data};
    // Sign of the extended sum differing from the DWIDTH-bit sign means overflow.
    if (sum_wide[DWIDTH] != sum_wide[DWIDTH-1])
      add_val = sum_wide[DWIDTH] ? {1'b1, {(DWIDTH-1){1'b0}}} : {1'b0, {(DWIDTH-1){1'b1}}};
    else
      add_val = sum_wide[DWIDTH-1:0];
  end
`else
  assign add_val = cur_val + in_data;
`endif

  // Pass 0 overwrites, so stale contents from an earlier or aborted job never leak.
  assign wr_val = (pass_reg == '0) ? in_data : add_val;

  // Scratchpad: one register per output position, written on input handshakes.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_spad
      logic [DWIDTH-1:0] entry_reg;
      always_ff @(posedge clk) begin
        if (in_hs && idx_reg[AW-1:0] == AW'(gi))
          entry_reg <= wr_val;
      end
      assign spad_rd[gi] = entry_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      len_reg       <= '0;
      passes_reg    <= '0;
      idx_reg       <= '0;
      pass_reg      <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            len_reg      <= len_eff;
            passes_reg   <= passes_eff;
            idx_reg      <= '0;
            pass_reg     <= '0;
            state_reg    <= ACCUM;
            busy_reg     <= 1'b1;
            in_ready_reg <= 1'b1;
          end
        end
        ACCUM: begin
          if (in_hs) begin
            if (idx_last) begin
              idx_reg  <= '0;
              pass_reg <= pass_reg + PW'(1);
              if (pass_last) begin
                state_reg     <= DRAIN;
                in_ready_reg  <= 1'b0;
                out_valid_reg <= 1'b1;
                // Entry 0 is being written this very edge when L==1; forward it.
                out_data_reg  <= (len_reg == LW'(1)) ? wr_val : spad_rd[0];
              end
            end else begin
              idx_reg <= idx_reg + LW'(1);
            end
          end
        end
        DRAIN: begin
          if (out_hs) begin
            if (idx_last) begin
              state_reg     <= IDLE;
              busy_reg      <= 1'b0;
              out_valid_reg <= 1'b0;
              out_data_reg  <= '0;
              done_reg      <= 1'b1;
              idx_reg       <= '0;
              pass_reg      <= '0;
            end else begin
              idx_reg      <= idx_reg + LW'(1);
              out_data_reg <= spad_rd[rd_next_addr];
            end
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

endmodule

// File: tb/tb_psum_accum.sv
// Testbench for psum_accum: directed vector table, hand-written multi-cycle
// corner cases, and randomized jobs checked against a pass-by-pass model.
module tb_psum_accum;

  localparam int DWIDTH = 16;
  localparam int DEPTH  = 16;
  localparam int LW     = $clog2(DEPTH) + 1;
  localparam int PW     = 4;
`ifdef PSUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [LW-1:0]     cfg_len = '0;
  logic [PW-1:0]     cfg_passes = '0;
  logic              busy;
  logic              done;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DWIDTH-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DWIDTH-1:0] out_data;

  psum_accum #(.DWIDTH(DWIDTH), .DEPTH(DEPTH), .LW(LW), .PW(PW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len),
    .cfg_passes(cfg_passes), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [15:0] in_q[$];
  logic [15:0] exp_q[$];

  typedef struct {
    string           name;
    int              clen;
    int              cpas;
    int              n_in;
    logic [5:0][15:0] din;   // element 0 is rightmost in the concatenation
    int              n_out;
    logic [2:0][15:0] dout;
  } vec_t;

  vec_t vt[5];

  function automatic vec_t mk(string name, int clen, int cpas, int n_in,
                              logic [5:0][15:0] din, int n_out, logic [2:0][15:0] dout);
    vec_t v;
    v.name = name; v.clen = clen; v.cpas = cpas; v.n_in = n_in;
    v.din = din; v.n_out = n_out; v.dout = dout;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  // Reference: signed Q4.12 add, saturating when the feature is built in.
  function automatic logic [15:0] ref_add(logic [15:0] a, logic [15:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (SAT && s > 32767)  return 16'h7FFF;
    if (SAT && s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  // Position k's psum is input k of pass 0 followed by input p*L+k of each later pass.
  function automatic void build_expected(int L, int P);
    logic [15:0] acc;
    exp_q.delete();
    for (int k = 0; k < L; k++) begin
      acc = in_q[k];
      for (int p = 1; p < P; p++) acc = ref_add(acc, in_q[p*L + k]);
      exp_q.push_back(acc);
    end
  endfunction

  task automatic start_job(input int clen, input int cpas);
    start = 1'b1; cfg_len = LW'(clen); cfg_passes = PW'(cpas);
    tick();
    start = 1'b0;
  endtask

  task automatic push_in(input logic [15:0] d, input string name);
    int n = 0;
    in_valid = 1'b1; in_data = d;
    while (!in_ready && n < 100) begin tick(); n++; end
    if (n >= 100) check({name, " in_ready timeout"}, 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_out(input logic [15:0] exp, input string name);
    int n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 100) begin tick(); n++; end
    if (n >= 100) check({name, " out_valid timeout"}, 0, 1);
    check(name, out_data, exp);
    $display("pop %s data=0x%04h", name, out_data);
    tick();
    out_ready = 1'b0;
  endtask

  // mode: 0 = continuous input, 1 = in_valid every other cycle, 2 = random bubbles
  task automatic run_job(input int clen, input int cpas, input int mode,
                         input int stall_pct, input string name);
    int L, P, n_in, n_out, cyc;
    bit hs_in, hs_out, finished, bad_done, early_out, unstable, prev_stall;
    logic [15:0] prev_data;
    L = (clen == 0 || clen > DEPTH) ? DEPTH : clen;
    P = (cpas == 0) ? 1 : cpas;
    build_expected(L, P);
    start_job(clen, cpas);
    n_in = 0; n_out = 0; cyc = 0; finished = 0;
    bad_done = 0; early_out = 0; unstable = 0; prev_stall = 0; prev_data = '0;
    while (!finished && cyc < 3000) begin
      in_valid = (n_in < L*P) && (mode == 0 || (mode == 1 && cyc % 2 == 0) ||
                                  (mode == 2 && $urandom_range(99) >= 30));
      in_data = in_valid ? in_q[n_in] : 16'($urandom);
      out_ready = (int'($urandom_range(99)) >= stall_pct);
      if (done) bad_done = 1;
      if (out_valid && n_in < L*P) early_out = 1;
      if (prev_stall && !(out_valid && out_data == prev_data)) unstable = 1;
      hs_in = in_valid && in_ready;
      hs_out = out_valid && out_ready;
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      if (hs_out) begin
        check($sformatf("%s out[%0d]", name, n_out), out_data, exp_q[n_out]);
        n_out++;
      end
      tick(); cyc++;
      if (hs_in) begin
        n_in++;
        if (n_in == L*P) begin
          check({name, " out_valid 1 cycle after last input"}, out_valid, 1);
          check({name, " in_ready low after last input"}, in_ready, 0);
        end
      end
      if (hs_out && n_out == L) finished = 1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    if (!finished) begin
      check({name, " job timeout"}, 0, 1);
      do_reset();
    end else begin
      check({name, " done pulse"}, done, 1);
      check({name, " busy low at done"}, busy, 0);
      check({name, " out_valid low at done"}, out_valid, 0);
      check({name, " protocol (early out/stray done/unstable)"},
            {29'd0, bad_done, early_out, unstable}, 0);
      // start edge to done = L*P + L edges, i.e. L*P + L + 1 cycles including start's
      if (mode == 0 && stall_pct == 0) check({name, " job length"}, cyc, L*P + L);
      tick();
      check({name, " done one cycle"}, done, 0);
    end
    $display("job %s L=%0d P=%0d outputs=%0d cycles=%0d", name, L, P, n_out, cyc);
  endtask

  task automatic fill_rand(input int n);
    in_q.delete();
    for (int i = 0; i < n; i++) in_q.push_back(16'($urandom));
  endtask

  initial begin
    vt[0] = mk("basic", 3, 2, 6,
               {16'h0800, 16'hF000, 16'h1000, 16'h0800, 16'h2000, 16'h1000}, 3,
               {16'h1000, 16'h1000, 16'h2000});
    vt[1] = mk("ovf_pos", 1, 2, 2, {64'd0, 16'h2000, 16'h7000}, 1,
               {32'd0, SAT ? 16'h7FFF : 16'h9000});
    vt[2] = mk("ovf_neg", 1, 2, 2, {64'd0, 16'hC000, 16'h9000}, 1,
               {32'd0, SAT ? 16'h8000 : 16'h5000});
    vt[3] = mk("single", 1, 1, 1, {80'd0, 16'h1234}, 1, {32'd0, 16'h1234});
    vt[4] = mk("passes0", 2, 0, 2, {64'd0, 16'h0022, 16'h0011}, 2,
               {16'd0, 16'h0022, 16'h0011});

    do_reset();
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset in_ready", in_ready, 0);
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);

    // Directed vector table
    for (int i = 0; i < 5; i++) begin
      start_job(vt[i].clen, vt[i].cpas);
      for (int k = 0; k < vt[i].n_in; k++) push_in(vt[i].din[k], vt[i].name);
      for (int k = 0; k < vt[i].n_out; k++)
        pop_out(vt[i].dout[k], $sformatf("%s out%0d", vt[i].name, k));
      check({vt[i].name, " done"}, done, 1);
      tick();
      check({vt[i].name, " done cleared"}, done, 0);
    end

    // Backpressure: first output must hold for 5 stalled cycles
    start_job(2, 1);
    push_in(16'h0100, "bp"); push_in(16'h0200, "bp");
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp hold valid c%0d", c), out_valid, 1);
      check($sformatf("bp hold data c%0d", c), out_data, 16'h0100);
      tick();
    end
    pop_out(16'h0100, "bp out0");
    pop_out(16'h0200, "bp out1");
    check("bp done", done, 1);
    tick();

    // Reset during ACCUM, pass 1, then a clean job
    start_job(3, 2);
    for (int k = 0; k < 4; k++) push_in(16'h1111, "rst");
    check("rst precondition busy", busy, 1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("rst busy", busy, 0);
    check("rst in_ready", in_ready, 0);
    check("rst out_valid", out_valid, 0);
    check("rst done", done, 0);
    start_job(2, 1);
    push_in(16'h0010, "rst2"); push_in(16'h0020, "rst2");
    pop_out(16'h0010, "rst2 out0");
    pop_out(16'h0020, "rst2 out1");
    check("rst2 done", done, 1);
    tick();

    // start pulsed during DRAIN is ignored
    start_job(3, 1);
    push_in(16'h0A00, "sd"); push_in(16'h0B00, "sd"); push_in(16'h0C00, "sd");
    pop_out(16'h0A00, "sd out0");
    start = 1'b1; cfg_len = LW'(1); cfg_passes = PW'(1);
    tick();
    start = 1'b0;
    check("sd still draining", out_valid, 1);
    check("sd data unchanged", out_data, 16'h0B00);
    pop_out(16'h0B00, "sd out1");
    pop_out(16'h0C00, "sd out2");
    check("sd done", done, 1);
    tick(); tick();
    check("sd no new job busy", busy, 0);
    check("sd no new job in_ready", in_ready, 0);

    // Bubbles: every other cycle, all 0x0400
    in_q.delete();
    for (int i = 0; i < 12; i++) in_q.push_back(16'h0400);
    run_job(4, 3, 1, 0, "bubble");

    // Clamping and timing with no stalls
    fill_rand(DEPTH * 2); run_job(0, 1, 0, 0, "len0");
    fill_rand(DEPTH * 2); run_job(20, 2, 0, 0, "len20");
    fill_rand(16);        run_job(5, 3, 0, 0, "nostall");

    // Randomized jobs with bubbles and backpressure
    for (int j = 0; j < 10; j++) begin
      fill_rand(DEPTH * 16);
      run_job($urandom_range(20), $urandom_range(5), 2, 30, $sformatf("rand%0d", j));
    end

    // Overflow-heavy random: large magnitudes
    for (int j = 0; j < 3; j++) begin
      in_q.delete();
      for (int i = 0; i < 64; i++)
        in_q.push_back(($urandom_range(1) != 0) ? 16'h6000 + 16'($urandom_range(4095))
                                               : 16'hA000 - 16'($urandom_range(4095)));
      run_job($urandom_range(1, 8), 4, 2, 20, $sformatf("big%0d", j));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
